mult_sequencer: RTL and testbench
=================================

MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 The block SHALL use a single clock and a synchronous, active-high reset: clk_i and rst_i, in that port order, ahead of all other ports.
REQ-002 clk_i  input  1  clock; all state SHALL update on the rising edge.
REQ-003 rst_i  input  1  synchronous reset, active-high.
REQ-004 start_i  input  1  multiply request, driven high while a MUL-class instruction (ALU control code 3'b100) occupies EX.
REQ-005 data1_i  input  32  multiplicand operand.
REQ-006 data2_i  input  32  multiplier operand.
REQ-007 stall_o  output  1  pipeline freeze request for PC, IF/ID and ID/EX.
REQ-008 done_o  output  1  one-cycle pulse: result_o is valid for write-back.
REQ-009 result_o  output  32  low 32 bits of the product.
REQ-010 busy_o  output  1  high in the RUN and DONE states.

Function
REQ-011 The block SHALL implement a shift-add iterative multiplier controlled by a 3-state FSM: IDLE, RUN, DONE.
REQ-012 Internal state SHALL consist of: 32-bit mcand register, 32-bit mplier register, 32-bit accumulator acc, 6-bit iteration counter cnt, and 32-bit result register.
REQ-013 IDLE with start_i=1 (cycle T) SHALL latch mcand<=data1_i and mplier<=data2_i, clear acc and cnt, and move to RUN.
REQ-014 stall_o SHALL be combinational: 1 when (state==IDLE and start_i=1 and rst_i=0) or state==RUN, else 0.
REQ-015 Each RUN cycle SHALL do the following:
- if mplier[0]=1, acc<=acc+mcand, truncated to 32 bits;
- mcand<=mcand<<1 and mplier<=mplier>>1, both zero-filled;
- cnt<=cnt+1.
REQ-016 RUN SHALL last exactly 32 cycles (T+1..T+32) with no early termination; when cnt reaches 31 the next state SHALL be DONE.
REQ-017 On entry to DONE (cycle T+33), result_o SHALL hold the final acc, done_o SHALL be 1, and stall_o SHALL be 0.
REQ-018 DONE SHALL last one cycle and then return to IDLE unconditionally; start_i SHALL be ignored in DONE.
REQ-019 Total latency SHALL be 33 cycles: stall_o high T..T+32, done_o high only at T+33.
REQ-020 start_i, data1_i and data2_i SHALL be ignored during RUN; only the operands latched at T are used.
REQ-021 result_o SHALL hold its value from DONE until the next DONE or reset.
REQ-022 The result SHALL equal (data1_i*data2_i) mod 2^32, which is identical for signed and unsigned operands.
REQ-023 A start_i still high in the IDLE cycle after DONE SHALL be accepted as a new request, giving back-to-back operations a 34-cycle period.
REQ-024 done_o SHALL be registered, with no combinational path from any input.

Reset
REQ-025 rst_i=1 at a clock edge SHALL force the following, from any state including mid-RUN:
- state=IDLE;
- acc, mcand, mplier, cnt and result_o to 0;
- done_o=0.
REQ-026 While rst_i=1, stall_o SHALL be 0 regardless of start_i, and a start_i coincident with rst_i SHALL be discarded.
REQ-027 An aborted operation SHALL produce no done_o pulse, and result_o SHALL read 0 after reset.

Verification
REQ-028 data1_i=3, data2_i=5, start_i pulsed at T -> stall_o high T..T+32, done_o high only at T+33, result_o=0x0000000F.
REQ-029 0xFFFFFFFF x 0xFFFFFFFF -> result_o=0x00000001 at T+33; 0x80000000 x 2 -> result_o=0x00000000 (wrap-around).
REQ-030 data1_i=7, data2_i=9 latched at T, then data1_i=0xDEAD and data2_i=0 driven at T+5 -> result_o=0x0000003F (operands held).
REQ-031 rst_i=1 at T+10 during RUN -> IDLE at T+11, stall_o=0, busy_o=0, result_o=0, and no done_o pulse for the next 40 cycles.
REQ-032 start_i held high continuously with 2 x 4 -> done_o pulses at T+33 and T+67, both with result_o=0x00000008; stall_o low at T+33 and high at T+34.
REQ-033 start_i=1 and rst_i=1 together at T -> stall_o=0 at T, state stays IDLE, and no done_o pulse follows.

Source files
------------

// File: rtl/mult_sequencer.sv
// rtl/mult_sequencer.sv - shift-add iterative 32x32 multiplier with pipeline stall control
// Produces the low 32 bits of the product 33 cycles after an accepted start.
module mult_sequencer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] data1_i,
  input  logic [31:0] data2_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [31:0] acc_q, acc_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] result_q, result_d;
  logic        done_q, done_d;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mcand_d  = data1_i;
          mplier_d = data2_i;
          acc_d    = 32'd0;
          cnt_d    = 6'd0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 6'd1;
        // Last iteration: capture the accumulator including this cycle's add.
        if (cnt_q == 6'd31) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          result_d = acc_d;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      mcand_q  <= 32'd0;
      mplier_q <= 32'd0;
      acc_q    <= 32'd0;
      cnt_q    <= 6'd0;
      result_q <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  // Freeze is requested in the accepting cycle itself, but never while reset is held.
  assign stall_o  = !rst_i && (((state_q == S_IDLE) && start_i) || (state_q == S_RUN));
  assign done_o   = done_q;
  assign result_o = result_q;
  assign busy_o   = (state_q == S_RUN) || (state_q == S_DONE);

endmodule

// File: tb/tb_mult_sequencer.sv
// tb/tb_mult_sequencer.sv - self-checking bench for mult_sequencer
// Expected products are queued at issue time and matched against each done_o pulse.
module tb_mult_sequencer;

  logic        clk_i;
  logic        rst_i;
  logic        start_i;
  logic [31:0] data1_i;
  logic [31:0] data2_i;
  logic        stall_o;
  logic        done_o;
  logic [31:0] result_o;
  logic        busy_o;

  int checks;
  int failures;
  logic [31:0] exp_q[$];

  mult_sequencer dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .data1_i  (data1_i),
    .data2_i  (data2_i),
    .stall_o  (stall_o),
    .done_o   (done_o),
    .result_o (result_o),
    .busy_o   (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Scoreboard: every done pulse must match the oldest outstanding product.
  always @(negedge clk_i) begin
    if (done_o === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_done: got result %08h with no request outstanding", result_o);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (result_o !== e) begin
          failures++;
          $display("FAIL sb_result: got %08h expected %08h", result_o, e);
        end
      end
    end
  end

  // Drives one start pulse and waits (bounded) for done; lat = -1 on timeout.
  task automatic issue_and_wait(input logic [31:0] a, input logic [31:0] b, output int lat);
    logic [31:0] p;
    p = a * b;
    data1_i = a;
    data2_i = b;
    exp_q.push_back(p);
    lat = -1;
    for (int k = 0; k <= 40; k++) begin
      start_i = (k == 0);
      @(negedge clk_i);
      if (done_o === 1'b1 && lat < 0) lat = k;
      @(posedge clk_i); #1;
      if (lat >= 0) break;
    end
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    start_i = 1'b1;
    data1_i = 32'd4;
    data2_i = 32'd4;
    @(negedge clk_i);
    checks++;
    if (stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b expected 0", stall_o); end
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++; $display("FAIL reset_flags: got done=%b busy=%b expected 0/0", done_o, busy_o);
    end
    checks++;
    if (result_o !== 32'd0) begin failures++; $display("FAIL reset_result: got %08h expected 00000000", result_o); end
    @(posedge clk_i); #1;
    start_i = 1'b0;
    rst_i = 1'b0;
  endtask

  task automatic test_basic();
    int bad_stall, bad_done;
    bad_stall = 0;
    bad_done = 0;
    data1_i = 32'd3;
    data2_i = 32'd5;
    exp_q.push_back(32'h0000000F);
    for (int k = 0; k <= 34; k++) begin
      start_i = (k == 0);
      @(negedge clk_i);
      if (stall_o !== (k <= 32)) begin
        bad_stall++;
        $display("FAIL basic_stall: cycle T+%0d got %b expected %b", k, stall_o, (k <= 32));
      end
      if (done_o !== (k == 33)) begin
        bad_done++;
        $display("FAIL basic_done: cycle T+%0d got %b expected %b", k, done_o, (k == 33));
      end
      if (k == 33) begin
        checks++;
        if (result_o !== 32'h0000000F || busy_o !== 1'b1) begin
          failures++; $display("FAIL basic_result: got %08h busy=%b expected 0000000f busy=1", result_o, busy_o);
        end
      end
      if (k == 34) begin
        checks++;
        if (result_o !== 32'h0000000F || busy_o !== 1'b0) begin
          failures++; $display("FAIL basic_hold: got %08h busy=%b expected 0000000f busy=0", result_o, busy_o);
        end
      end
      @(posedge clk_i); #1;
    end
    checks++;
    if (bad_stall != 0) failures++;
    checks++;
    if (bad_done != 0) failures++;
  endtask

  task automatic test_wrap();
    int lat;
    logic [31:0] a, b;
    issue_and_wait(32'hFFFFFFFF, 32'hFFFFFFFF, lat);
    checks++;
    if (lat != 33) begin failures++; $display("FAIL wrap_ones_latency: got %0d expected 33", lat); end
    checks++;
    if (result_o !== 32'h00000001) begin failures++; $display("FAIL wrap_ones: got %08h expected 00000001", result_o); end
    issue_and_wait(32'h80000000, 32'h00000002, lat);
    checks++;
    if (lat != 33) begin failures++; $display("FAIL wrap_msb_latency: got %0d expected 33", lat); end
    checks++;
    if (result_o !== 32'h00000000) begin failures++; $display("FAIL wrap_msb: got %08h expected 00000000", result_o); end
    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      b = $urandom;
      issue_and_wait(a, b, lat);
      checks++;
      if (lat != 33) begin failures++; $display("FAIL random_latency: %08h*%08h got %0d expected 33", a, b, lat); end
    end
  endtask

  task automatic test_operand_hold();
    int lat;
    lat = -1;
    data1_i = 32'd7;
    data2_i = 32'd9;
    exp_q.push_back(32'h0000003F);
    for (int k = 0; k <= 40; k++) begin
      start_i = (k == 0);
      if (k == 5) begin
        data1_i = 32'h0000DEAD;
        data2_i = 32'd0;
      end
      @(negedge clk_i);
      if (done_o === 1'b1 && lat < 0) lat = k;
      @(posedge clk_i); #1;
      if (lat >= 0) break;
    end
    start_i = 1'b0;
    checks++;
    if (lat != 33) begin failures++; $display("FAIL hold_latency: got %0d expected 33", lat); end
    checks++;
    if (result_o !== 32'h0000003F) begin failures++; $display("FAIL hold_result: got %08h expected 0000003f", result_o); end
  endtask

  task automatic test_abort();
    int seen_done;
    data1_i = 32'd3;
    data2_i = 32'd5;
    exp_q.push_back(32'h0000000F);
    for (int k = 0; k < 10; k++) begin
      start_i = (k == 0);
      @(posedge clk_i); #1;
    end
    rst_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (stall_o !== 1'b0) begin failures++; $display("FAIL abort_stall_in_reset: got %b expected 0", stall_o); end
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    exp_q.delete();
    @(negedge clk_i);
    checks++;
    if (stall_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++; $display("FAIL abort_idle: got stall=%b busy=%b expected 0/0", stall_o, busy_o);
    end
    checks++;
    if (result_o !== 32'd0) begin failures++; $display("FAIL abort_result: got %08h expected 00000000", result_o); end
    seen_done = 0;
    for (int k = 0; k < 40; k++) begin
      if (done_o !== 1'b0) seen_done++;
      @(negedge clk_i);
    end
    checks++;
    if (seen_done != 0) begin failures++; $display("FAIL abort_no_done: got %0d pulses expected 0", seen_done); end
    @(posedge clk_i); #1;
  endtask

  task automatic test_back_to_back();
    int bad;
    logic es, ed;
    bad = 0;
    data1_i = 32'd2;
    data2_i = 32'd4;
    for (int k = 0; k <= 68; k++) begin
      start_i = (k < 68);
      if (k == 0 || k == 34) exp_q.push_back(32'h00000008);
      @(negedge clk_i);
      es = (k <= 32) || (k >= 34 && k <= 66);
      ed = (k == 33) || (k == 67);
      if (stall_o !== es || done_o !== ed) begin
        bad++;
        $display("FAIL b2b_timing: cycle T+%0d got stall=%b done=%b expected %b/%b", k, stall_o, done_o, es, ed);
      end
      if (ed) begin
        checks++;
        if (result_o !== 32'h00000008) begin
          failures++; $display("FAIL b2b_result: cycle T+%0d got %08h expected 00000008", k, result_o);
        end
      end
      @(posedge clk_i); #1;
    end
    checks++;
    if (bad != 0) failures++;
  endtask

  task automatic test_start_with_reset();
    int bad;
    bad = 0;
    rst_i = 1'b1;
    start_i = 1'b1;
    data1_i = 32'd5;
    data2_i = 32'd5;
    @(negedge clk_i);
    checks++;
    if (stall_o !== 1'b0) begin failures++; $display("FAIL rst_start_stall: got %b expected 0", stall_o); end
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    start_i = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_i);
      if (done_o !== 1'b0 || busy_o !== 1'b0 || stall_o !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL rst_start_ignored: got %0d active cycles expected 0", bad); end
    @(posedge clk_i); #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_i = 1'b1;
    start_i = 1'b0;
    data1_i = 32'd0;
    data2_i = 32'd0;
    @(posedge clk_i); #1;
    test_reset();
    test_basic();
    test_wrap();
    test_operand_hold();
    test_abort();
    test_back_to_back();
    test_start_with_reset();
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL sb_drain: got %0d outstanding expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
